// File: rtl/tqvp_dlmiles_i2c_pkg.sv
// Shared constants for the I2C receive path: RX shifter state encoding,
// byte geometry and counter widths.
package tqvp_dlmiles_i2c_pkg;

  localparam int CNT_W = 4;
  localparam int I2C_BITS_PER_BYTE = 8;

  // RX shifter states
  localparam logic [1:0] RXS_IDLE     = 2'd0;
  localparam logic [1:0] RXS_WAIT_LOW = 2'd1;
  localparam logic [1:0] RXS_SHIFT    = 2'd2;
  localparam logic [1:0] RXS_ACK      = 2'd3;

  // Count value held before the rise that completes a byte
  localparam logic [CNT_W-1:0] RX_LAST_BIT = CNT_W'(I2C_BITS_PER_BYTE - 1);

endpackage

// File: rtl/tqvp_dlmiles_i2c_glitchfilt.sv
// 1-bit glitch filter: the output follows the input only after the input has
// differed from the output for FILTER_LEN consecutive clk samples. Any sample
// agreeing with the output clears the run counter. Output resets to 1 (idle bus).
module tqvp_dlmiles_i2c_glitchfilt
  import tqvp_dlmiles_i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive mismatching samples; flip the output on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= 1'b1;
      cnt <= '0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt >= LAST) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tqvp_dlmiles_i2c_rxshift.sv
// I2C receive deserialiser. Armed once per byte by the FSM, samples SDA on
// SCL rises (MSB first), then captures the ACK bit. START/STOP detection and
// bus-busy tracking run in every state.
// Optional: define TQVP_DLMILES_I2C_RXSHIFT_FILTER_EN to put a FILTER_LEN
// glitch filter on both lines.
module tqvp_dlmiles_i2c_rxshift
  import tqvp_dlmiles_i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic       rx_arm_i,
  input  logic       rx_abort_i,
  output logic [7:0] rxd_data_o,
  output logic       rxd_valid_o,
  output logic       ack_o,
  output logic       ack_valid_o,
  output logic       busy_o,
  output logic       start_det_o,
  output logic       stop_det_o,
  output logic       bus_busy_o,
  output logic       err_io_o
);

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_len
    $error("FILTER_LEN must be in 1..15");
  end

  logic scl_f, sda_f;

`ifdef TQVP_DLMILES_I2C_RXSHIFT_FILTER_EN
  tqvp_dlmiles_i2c_glitchfilt #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .d(scl_i), .q(scl_f)
  );
  tqvp_dlmiles_i2c_glitchfilt #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .d(sda_i), .q(sda_f)
  );
`else
  assign scl_f = scl_i;
  assign sda_f = sda_i;
`endif

  logic scl_q, sda_q;
  logic rise, start_c, stop_c;
  logic [1:0] state;
  logic [CNT_W-1:0] bit_cnt;
  // Only the first seven bits need holding; the eighth goes straight to rxd_data_o
  logic [6:0] shreg;

  assign rise    = scl_f & ~scl_q;
  assign start_c = scl_f & scl_q & ~sda_f &  sda_q;
  assign stop_c  = scl_f & scl_q &  sda_f & ~sda_q;
  assign busy_o  = (state != RXS_IDLE);

  // Previous-sample registers; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // Bus condition strobes and busy level, independent of capture state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_det_o <= 1'b0;
      stop_det_o  <= 1'b0;
      bus_busy_o  <= 1'b0;
    end else begin
      start_det_o <= start_c;
      stop_det_o  <= stop_c;
      if (start_c)     bus_busy_o <= 1'b1;
      else if (stop_c) bus_busy_o <= 1'b0;
    end
  end

  // Capture FSM: abort beats everything, bus conditions mid-byte are errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RXS_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      rxd_data_o  <= '0;
      rxd_valid_o <= 1'b0;
      ack_o       <= 1'b0;
      ack_valid_o <= 1'b0;
      err_io_o    <= 1'b0;
    end else begin
      rxd_valid_o <= 1'b0;
      ack_valid_o <= 1'b0;
      err_io_o    <= 1'b0;
      case (state)
        RXS_IDLE: begin
          if (rx_arm_i && !rx_abort_i) begin
            state   <= RXS_WAIT_LOW;
            bit_cnt <= '0;
          end
        end
        RXS_WAIT_LOW: begin
          // Skip any high phase already under way when armed
          if (rx_abort_i)  state <= RXS_IDLE;
          else if (!scl_f) state <= RXS_SHIFT;
        end
        RXS_SHIFT: begin
          if (rx_abort_i) begin
            state <= RXS_IDLE;
          end else if (start_c || stop_c) begin
            err_io_o <= 1'b1;
            state    <= RXS_IDLE;
          end else if (rise) begin
            shreg   <= {shreg[5:0], sda_f};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == RX_LAST_BIT) begin
              rxd_data_o  <= {shreg, sda_f};
              rxd_valid_o <= 1'b1;
              state       <= RXS_ACK;
            end
          end
        end
        default: begin // RXS_ACK
          if (rx_abort_i) begin
            state <= RXS_IDLE;
          end else if (start_c || stop_c) begin
            err_io_o <= 1'b1;
            state    <= RXS_IDLE;
          end else if (rise) begin
            ack_o       <= sda_f;
            ack_valid_o <= 1'b1;
            state       <= RXS_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_rxshift.sv
// Directed bench for the I2C RX shifter. Expected bytes/ACKs are queued when
// driven and popped by a monitor on each strobe; timing checks are inline.
module tb_tqvp_dlmiles_i2c_rxshift;

`ifdef TQVP_DLMILES_I2C_RXSHIFT_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 0;
`endif
  localparam int HOLD = LAT + 2;

  logic clk = 1'b0;
  logic rst, scl, sda, arm, abort;
  logic [7:0] rxd_data;
  logic rxd_valid, ack, ack_valid, busy, start_det, stop_det, bus_busy, err_io;

  tqvp_dlmiles_i2c_rxshift #(.FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda),
    .rx_arm_i(arm), .rx_abort_i(abort),
    .rxd_data_o(rxd_data), .rxd_valid_o(rxd_valid),
    .ack_o(ack), .ack_valid_o(ack_valid), .busy_o(busy),
    .start_det_o(start_det), .stop_det_o(stop_det),
    .bus_busy_o(bus_busy), .err_io_o(err_io)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int n_rxv = 0, n_ackv = 0;
  logic [7:0] exp_data[$];
  logic exp_ack[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    scl = 1'b0; wait_n(HOLD);
    sda = b;    wait_n(HOLD);
    scl = 1'b1; wait_n(HOLD + 1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic arm_pulse();
    arm = 1'b1; wait_n(1); arm = 1'b0;
  endtask

  // Scoreboard monitor: every strobe must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (rxd_valid) begin
        n_rxv++;
        if (exp_data.size() == 0) check("rxd_valid_unexpected", rxd_valid, 0);
        else check("rxd_data", rxd_data, exp_data.pop_front());
      end
      if (ack_valid) begin
        n_ackv++;
        if (exp_ack.size() == 0) check("ack_valid_unexpected", ack_valid, 0);
        else check("ack", ack, exp_ack.pop_front());
      end
    end
  end

  initial begin
    int r0, a0;
    rst = 1'b1; scl = 1'b1; sda = 1'b1; arm = 1'b0; abort = 1'b0;
    wait_n(3);
    check("rst_rxd_data", rxd_data, 0);
    check("rst_rxd_valid", rxd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_bus_busy", bus_busy, 0);
    check("rst_start_det", start_det, 0);
    rst = 1'b0;
    wait_n(2);

    // Reset mid-SHIFT after 3 bits
    arm_pulse();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("busy_mid_shift", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rxd_valid", rxd_valid, 0);
    check("midrst_ack_valid", ack_valid, 0);
    @(negedge clk); rst = 1'b0;
    wait_n(2);
    r0 = n_rxv; a0 = n_ackv;
    send_bit(1'b1); send_bit(1'b1);
    check("noarm_rxv", n_rxv, r0);
    check("noarm_busy", busy, 0);

    // 0xA5 with ACK
    exp_data.push_back(8'hA5); exp_ack.push_back(1'b0);
    r0 = n_rxv; a0 = n_ackv;
    arm_pulse();
    send_byte(8'hA5);
    scl = 1'b0; wait_n(HOLD);
    sda = 1'b0; wait_n(HOLD);
    scl = 1'b1; wait_n(LAT);
    check("busy_before_ack_rise", busy, 1);
    wait_n(1);
    check("busy_after_ack_rise", busy, 0);
    check("ack_valid_timing", ack_valid, 1);
    wait_n(HOLD);
    check("a5_rxv_count", n_rxv, r0 + 1);
    check("a5_ackv_count", n_ackv, a0 + 1);

    // Arm while SCL high, 0x3C with NACK
    exp_data.push_back(8'h3C); exp_ack.push_back(1'b1);
    r0 = n_rxv; a0 = n_ackv;
    arm_pulse();
    send_byte(8'h3C);
    send_bit(1'b1);
    check("3c_rxv_count", n_rxv, r0 + 1);
    check("3c_ackv_count", n_ackv, a0 + 1);
    check("3c_data_hold", rxd_data, 8'h3C);

    // START inside a byte
    r0 = n_rxv;
    arm_pulse();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("pre_start_bus_busy", bus_busy, 0);
    sda = 1'b0; wait_n(LAT + 1);
    check("err_start_det", start_det, 1);
    check("err_io_pulse", err_io, 1);
    check("err_bus_busy", bus_busy, 1);
    check("err_busy", busy, 0);
    wait_n(1);
    check("err_start_det_1cyc", start_det, 0);
    check("err_io_1cyc", err_io, 0);
    check("err_rxd_data_kept", rxd_data, 8'h3C);
    check("err_no_rxv", n_rxv, r0);

    // Idle STOP / START / STOP
    sda = 1'b1; wait_n(LAT + 1);
    check("stop1_det", stop_det, 1);
    check("stop1_bus_busy", bus_busy, 0);
    check("stop1_no_err", err_io, 0);
    wait_n(1);
    check("stop1_1cyc", stop_det, 0);
    sda = 1'b0; wait_n(LAT + 1);
    check("start_det", start_det, 1);
    check("start_bus_busy", bus_busy, 1);
    check("start_no_err", err_io, 0);
    wait_n(1);
    check("start_1cyc", start_det, 0);
    sda = 1'b1; wait_n(LAT + 1);
    check("stop2_det", stop_det, 1);
    check("stop2_bus_busy", bus_busy, 0);
    check("stop2_no_err", err_io, 0);

    // Abort mid-byte, and abort beating a simultaneous arm
    r0 = n_rxv; a0 = n_ackv;
    arm_pulse();
    send_bit(1'b1); send_bit(1'b0);
    abort = 1'b1; wait_n(1); abort = 1'b0;
    check("abort_busy", busy, 0);
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    arm = 1'b1; abort = 1'b1; wait_n(1); arm = 1'b0; abort = 1'b0;
    check("arm_abort_busy", busy, 0);
    check("abort_no_rxv", n_rxv, r0);
    check("abort_no_ackv", n_ackv, a0);

`ifdef TQVP_DLMILES_I2C_RXSHIFT_FILTER_EN
    // 2-clk SCL low glitch during a high phase must not count as a rise
    exp_data.push_back(8'hFF); exp_ack.push_back(1'b0);
    r0 = n_rxv;
    arm_pulse();
    for (int i = 0; i < 8; i++) begin
      scl = 1'b0; wait_n(HOLD);
      sda = 1'b1; wait_n(HOLD);
      scl = 1'b1; wait_n(HOLD + 1);
      if (i == 3) begin
        scl = 1'b0; wait_n(2);
        scl = 1'b1; wait_n(HOLD + 1);
      end
    end
    check("glitch_rxv_count", n_rxv, r0 + 1);
    send_bit(1'b0);
`endif

    wait_n(4);
    check("data_queue_empty", exp_data.size(), 0);
    check("ack_queue_empty", exp_ack.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
